// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the cache-to-memory arbiter: bus commands, owner
// encoding, tag sizing and the tag-table entry layout.
package mem_bus_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;
  localparam int TAG_W        = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache request/return signals and the processor-memory bus.
// master: the arbiter; slave: caches + memory model driving the other side.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // icache side
  logic                icache_req;
  logic [ADDR_W-1:0]   icache_addr;
  logic                icache_ack;
  logic [TAG_W-1:0]    icache_tag;
  logic                icache_data_valid;
  logic [DATA_W-1:0]   icache_data;
  // dcache side
  logic                dcache_req;
  BUS_COMMAND          dcache_cmd;
  logic [ADDR_W-1:0]   dcache_addr;
  logic [DATA_W-1:0]   dcache_wdata;
  logic                dcache_ack;
  logic [TAG_W-1:0]    dcache_tag;
  logic                dcache_data_valid;
  logic [DATA_W-1:0]   dcache_data;
  // memory side
  BUS_COMMAND          proc2mem_command;
  logic [ADDR_W-1:0]   proc2mem_addr;
  logic [DATA_W-1:0]   proc2mem_data;
  logic [TAG_W-1:0]    mem2proc_response;
  logic [DATA_W-1:0]   mem2proc_data;
  logic [TAG_W-1:0]    mem2proc_tag;
  // status
  logic [TAG_W-1:0]    outstanding_cnt;
  logic                stray_tag_err;

  modport master (
    input  icache_req, icache_addr,
    output icache_ack, icache_tag, icache_data_valid, icache_data,
    input  dcache_req, dcache_cmd, dcache_addr, dcache_wdata,
    output dcache_ack, dcache_tag, dcache_data_valid, dcache_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output outstanding_cnt, stray_tag_err
  );

  modport slave (
    output icache_req, icache_addr,
    input  icache_ack, icache_tag, icache_data_valid, icache_data,
    output dcache_req, dcache_cmd, dcache_addr, dcache_wdata,
    input  dcache_ack, dcache_tag, dcache_data_valid, dcache_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  outstanding_cnt, stray_tag_err
  );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for outstanding memory tags. One entry per tag; entry 0 is
// never written since response 0 means rejection. A same-cycle clear and
// set of one tag resolves to the set (new owner wins).
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  MEM_OWNER         set_owner_i,
  input  logic             clr_en_i,
  input  logic [TAG_W-1:0] lkp_tag_i,
  output tag_entry_t       lkp_entry_o,
  output logic [TAG_W-1:0] cnt_o
);

  tag_entry_t [NUM_TAGS:0] entries_q, entries_d;

  // Next table contents: clear the returning tag first, then record a new accept.
  always_comb begin
    entries_d = entries_q;
    if (clr_en_i) entries_d[lkp_tag_i].valid = 1'b0;
    if (set_en_i) entries_d[set_tag_i] = '{valid: 1'b1, owner: set_owner_i};
  end

  // Table state register, wiped on reset so all ownership is forgotten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) entries_q <= '0;
    else       entries_q <= entries_d;
  end

  // Lookup for the returning tag and live-entry count.
  always_comb begin
    lkp_entry_o = entries_q[lkp_tag_i];
    cnt_o       = '0;
    for (int i = 0; i <= NUM_TAGS; i++)
      cnt_o = cnt_o + TAG_W'(entries_q[i].valid);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between icache fills and dcache
// loads/stores. dcache has priority unless icache has been denied for
// STARVE_LIMIT cycles. Load tags are recorded so returning data is steered
// back to the cache that issued it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_q, starve_d;
  logic            stray_q, stray_d;
  logic            d_ok, i_ok, win_i, win_d, accepted;
  logic            set_en, ret_hit;
  tag_entry_t      lkp_entry;
  logic [TAG_W-1:0] cnt;

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tags (
    .clock       (clock),
    .reset       (reset),
    .set_en_i    (set_en),
    .set_tag_i   (bus.mem2proc_response),
    .set_owner_i (win_i ? OWN_ICACHE : OWN_DCACHE),
    .clr_en_i    (ret_hit),
    .lkp_tag_i   (bus.mem2proc_tag),
    .lkp_entry_o (lkp_entry),
    .cnt_o       (cnt)
  );

  // Winner selection, bus drive and acks; all combinational so an accept
  // lands in the same cycle the memory responds.
  always_comb begin
    d_ok     = bus.dcache_req && (bus.dcache_cmd != BUS_NONE);
    i_ok     = bus.icache_req;
    win_i    = i_ok && (!d_ok || (starve_q == SC_W'(STARVE_LIMIT)));
    win_d    = !win_i && d_ok;
    accepted = (bus.mem2proc_response != '0);

    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.icache_ack       = 1'b0;
    bus.icache_tag       = '0;
    bus.dcache_ack       = 1'b0;
    bus.dcache_tag       = '0;
    set_en               = 1'b0;

    if (win_i) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = bus.icache_addr;
      bus.icache_ack       = accepted;
      bus.icache_tag       = bus.mem2proc_response;
      set_en               = accepted;
    end else if (win_d) begin
      bus.proc2mem_command = bus.dcache_cmd;
      bus.proc2mem_addr    = bus.dcache_addr;
      bus.proc2mem_data    = bus.dcache_wdata;
      bus.dcache_ack       = accepted;
      bus.dcache_tag       = bus.mem2proc_response;
      // stores finish on acceptance and never own a tag
      set_en               = accepted && (bus.dcache_cmd == BUS_LOAD);
    end
  end

  // Return steering: pass data through to the recorded owner, flag strays.
  always_comb begin
    ret_hit               = (bus.mem2proc_tag != '0) && lkp_entry.valid;
    bus.icache_data_valid = ret_hit && (lkp_entry.owner == OWN_ICACHE);
    bus.dcache_data_valid = ret_hit && (lkp_entry.owner == OWN_DCACHE);
    bus.icache_data       = bus.icache_data_valid ? bus.mem2proc_data : '0;
    bus.dcache_data       = bus.dcache_data_valid ? bus.mem2proc_data : '0;
    stray_d               = stray_q || ((bus.mem2proc_tag != '0) && !lkp_entry.valid);
  end

  // Starvation counter: counts consecutive denied icache cycles, saturating.
  always_comb begin
    starve_d = '0;
    if (bus.icache_req && !bus.icache_ack)
      starve_d = (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
  end

  // Arbiter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      stray_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stray_q  <= stray_d;
    end
  end

  assign bus.outstanding_cnt = cnt;
  assign bus.stray_tag_err   = stray_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge,
// combinational outputs are checked 1ns later, registered state 1ns after
// the rising edge.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clock, reset;
  int   errors = 0;
  int   checks = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_if.icache_req        = 1'b0;
    bus_if.icache_addr       = '0;
    bus_if.dcache_req        = 1'b0;
    bus_if.dcache_cmd        = BUS_NONE;
    bus_if.dcache_addr       = '0;
    bus_if.dcache_wdata      = '0;
    bus_if.mem2proc_response = '0;
    bus_if.mem2proc_data     = '0;
    bus_if.mem2proc_tag      = '0;
  endtask

  // advance to the next falling edge and clear all inputs
  task automatic next();
    @(negedge clock);
    idle();
  endtask

  // let the rising edge happen, then sample registered state
  task automatic edge_sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    chk("rst_outstanding", 64'(bus_if.outstanding_cnt), 64'd0);
    chk("rst_stray",       64'(bus_if.stray_tag_err), 64'd0);
    chk("rst_cmd",         64'(bus_if.proc2mem_command), 64'(BUS_NONE));
    chk("rst_acks",        64'({bus_if.icache_ack, bus_if.dcache_ack}), 64'd0);
    chk("rst_valids",      64'({bus_if.icache_data_valid, bus_if.dcache_data_valid}), 64'd0);
    chk("rst_addr",        64'(bus_if.proc2mem_addr), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // dcache load accepted with tag 3, then its data returns
    next();
    bus_if.dcache_req = 1'b1; bus_if.dcache_cmd = BUS_LOAD; bus_if.dcache_addr = 32'h1000;
    bus_if.mem2proc_response = 4'd3;
    #1;
    chk("ld_dack", 64'(bus_if.dcache_ack), 64'd1);
    chk("ld_dtag", 64'(bus_if.dcache_tag), 64'd3);
    chk("ld_iack", 64'(bus_if.icache_ack), 64'd0);
    chk("ld_cmd",  64'(bus_if.proc2mem_command), 64'(BUS_LOAD));
    chk("ld_addr", 64'(bus_if.proc2mem_addr), 64'h1000);
    edge_sample();
    chk("ld_outst", 64'(bus_if.outstanding_cnt), 64'd1);
    next();
    bus_if.mem2proc_tag = 4'd3; bus_if.mem2proc_data = 64'hDEAD;
    #1;
    chk("ret_dvalid", 64'(bus_if.dcache_data_valid), 64'd1);
    chk("ret_ddata",  bus_if.dcache_data, 64'hDEAD);
    chk("ret_ivalid", 64'(bus_if.icache_data_valid), 64'd0);
    chk("ret_idle_cmd", 64'(bus_if.proc2mem_command), 64'(BUS_NONE));
    edge_sample();
    chk("ret_outst", 64'(bus_if.outstanding_cnt), 64'd0);

    // dcache store: acked, no table entry
    next();
    bus_if.dcache_req = 1'b1; bus_if.dcache_cmd = BUS_STORE; bus_if.dcache_addr = 32'h2000;
    bus_if.dcache_wdata = 64'h55; bus_if.mem2proc_response = 4'd5;
    #1;
    chk("st_dack", 64'(bus_if.dcache_ack), 64'd1);
    chk("st_dtag", 64'(bus_if.dcache_tag), 64'd5);
    chk("st_cmd",  64'(bus_if.proc2mem_command), 64'(BUS_STORE));
    chk("st_addr", 64'(bus_if.proc2mem_addr), 64'h2000);
    chk("st_data", bus_if.proc2mem_data, 64'h55);
    edge_sample();
    chk("st_outst", 64'(bus_if.outstanding_cnt), 64'd0);

    // both requesting every cycle: dcache wins 0-3, icache 4, dcache again 5
    begin
      logic [3:0] rsp [6];
      logic       iwin [6];
      rsp  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8};
      iwin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 6; c++) begin
        next();
        bus_if.icache_req = 1'b1; bus_if.icache_addr = 32'h3000;
        bus_if.dcache_req = 1'b1; bus_if.dcache_cmd = BUS_LOAD; bus_if.dcache_addr = 32'h4000;
        bus_if.mem2proc_response = rsp[c];
        #1;
        chk($sformatf("starve_iack_c%0d", c), 64'(bus_if.icache_ack), 64'(iwin[c]));
        chk($sformatf("starve_dack_c%0d", c), 64'(bus_if.dcache_ack), 64'(!iwin[c]));
        chk($sformatf("starve_addr_c%0d", c), 64'(bus_if.proc2mem_addr),
            iwin[c] ? 64'h3000 : 64'h4000);
        edge_sample();
      end
      chk("starve_outst", 64'(bus_if.outstanding_cnt), 64'd6);
    end

    // drain: tag 6 belongs to icache, the rest to dcache
    begin
      logic [3:0] dr [6];
      dr = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd6};
      for (int k = 0; k < 6; k++) begin
        next();
        bus_if.mem2proc_tag = dr[k]; bus_if.mem2proc_data = 64'h100 + 64'(k);
        #1;
        chk($sformatf("drain_dv_t%0d", dr[k]), 64'(bus_if.dcache_data_valid), 64'(k < 5));
        chk($sformatf("drain_iv_t%0d", dr[k]), 64'(bus_if.icache_data_valid), 64'(k == 5));
        edge_sample();
      end
      chk("drain_outst", 64'(bus_if.outstanding_cnt), 64'd0);
      chk("drain_stray", 64'(bus_if.stray_tag_err), 64'd0);
    end

    // icache rejected 3 cycles, accepted with tag 7 on the 4th
    for (int c = 0; c < 4; c++) begin
      next();
      bus_if.icache_req = 1'b1; bus_if.icache_addr = 32'h5000;
      bus_if.mem2proc_response = (c == 3) ? 4'd7 : 4'd0;
      #1;
      chk($sformatf("rej_iack_c%0d", c), 64'(bus_if.icache_ack), 64'(c == 3));
      chk($sformatf("rej_addr_c%0d", c), 64'(bus_if.proc2mem_addr), 64'h5000);
      chk($sformatf("rej_cmd_c%0d", c),  64'(bus_if.proc2mem_command), 64'(BUS_LOAD));
      edge_sample();
      chk($sformatf("rej_outst_c%0d", c), 64'(bus_if.outstanding_cnt), 64'(c == 3));
    end
    chk("rej_itag_none", 64'(bus_if.icache_tag), 64'd7);
    next();
    bus_if.mem2proc_tag = 4'd7; bus_if.mem2proc_data = 64'h77;
    #1;
    chk("rej_ret_iv", 64'(bus_if.icache_data_valid), 64'd1);
    chk("rej_ret_id", bus_if.icache_data, 64'h77);
    chk("rej_ret_dv", 64'(bus_if.dcache_data_valid), 64'd0);
    edge_sample();
    chk("rej_ret_outst", 64'(bus_if.outstanding_cnt), 64'd0);

    // tag 9: dcache owns it, then returns while icache is accepted with tag 9
    next();
    bus_if.dcache_req = 1'b1; bus_if.dcache_cmd = BUS_LOAD; bus_if.dcache_addr = 32'h6000;
    bus_if.mem2proc_response = 4'd9;
    edge_sample();
    next();
    bus_if.icache_req = 1'b1; bus_if.icache_addr = 32'h7000;
    bus_if.mem2proc_response = 4'd9;
    bus_if.mem2proc_tag = 4'd9; bus_if.mem2proc_data = 64'hBEEF;
    #1;
    chk("same_dv",   64'(bus_if.dcache_data_valid), 64'd1);
    chk("same_dd",   bus_if.dcache_data, 64'hBEEF);
    chk("same_iv",   64'(bus_if.icache_data_valid), 64'd0);
    chk("same_iack", 64'(bus_if.icache_ack), 64'd1);
    chk("same_itag", 64'(bus_if.icache_tag), 64'd9);
    edge_sample();
    chk("same_outst", 64'(bus_if.outstanding_cnt), 64'd1);
    next();
    bus_if.mem2proc_tag = 4'd9; bus_if.mem2proc_data = 64'hCAFE;
    #1;
    chk("same2_iv", 64'(bus_if.icache_data_valid), 64'd1);
    chk("same2_dv", 64'(bus_if.dcache_data_valid), 64'd0);
    chk("same2_id", bus_if.icache_data, 64'hCAFE);
    edge_sample();
    chk("same2_outst", 64'(bus_if.outstanding_cnt), 64'd0);

    // stray return on tag 2
    next();
    bus_if.mem2proc_tag = 4'd2; bus_if.mem2proc_data = 64'h22;
    #1;
    chk("stray_dv", 64'(bus_if.dcache_data_valid), 64'd0);
    chk("stray_iv", 64'(bus_if.icache_data_valid), 64'd0);
    chk("stray_pre", 64'(bus_if.stray_tag_err), 64'd0);
    edge_sample();
    chk("stray_set", 64'(bus_if.stray_tag_err), 64'd1);
    // leave one load outstanding (tag 11), confirm error is sticky
    next();
    bus_if.dcache_req = 1'b1; bus_if.dcache_cmd = BUS_LOAD; bus_if.dcache_addr = 32'h8000;
    bus_if.mem2proc_response = 4'd11;
    edge_sample();
    chk("stray_held", 64'(bus_if.stray_tag_err), 64'd1);
    chk("pre_rst_outst", 64'(bus_if.outstanding_cnt), 64'd1);

    // asynchronous reset mid-cycle clears everything immediately
    next();
    #2 reset = 1'b1;
    #1;
    chk("arst_stray", 64'(bus_if.stray_tag_err), 64'd0);
    chk("arst_outst", 64'(bus_if.outstanding_cnt), 64'd0);
    reset = 1'b0;
    // late return for dropped tag 11 is now a stray
    next();
    bus_if.mem2proc_tag = 4'd11; bus_if.mem2proc_data = 64'hB;
    #1;
    chk("late_dv", 64'(bus_if.dcache_data_valid), 64'd0);
    edge_sample();
    chk("late_stray", 64'(bus_if.stray_tag_err), 64'd1);

    next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor-to-memory bus between the instruction cache (miss fills) and the data cache (load fills and store write-backs issued on behalf of the LSQ). Grants one requester per cycle, with dcache priority and an icache starvation guard. Records the owner of every outstanding tag and steers returning memory data to the correct cache. Sits between both caches and the memory model, replacing direct cache-to-memory wiring.

## Interface
- `NUM_TAGS`, 15: number of memory transaction tags (tag 0 = "no tag"); tag width is 4.
- `STARVE_LIMIT`, 4: consecutive cycles icache may be denied before it takes priority.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `icache_req`  in  1  icache has a load request pending (held until acked)
- `icache_addr`  in  32  icache block address
- `icache_ack`  out  1  icache request accepted by memory this cycle
- `icache_tag`  out  4  tag assigned to accepted icache request
- `icache_data_valid`  out  1  returning data belongs to icache
- `icache_data`  out  64  returning data
- `dcache_req`  in  1  dcache request pending (held until acked)
- `dcache_cmd`  in  BUS_COMMAND  BUS_LOAD or BUS_STORE
- `dcache_addr`  in  32  dcache address
- `dcache_wdata`  in  64  store data
- `dcache_ack`, `dcache_tag`, `dcache_data_valid`, `dcache_data`: out, same meaning as the icache equivalents
- `proc2mem_command`  out  BUS_COMMAND  command to memory
- `proc2mem_addr`  out  32 / `proc2mem_data`  out  64
- `mem2proc_response`  in  4  accepted tag, 0 = rejected
- `mem2proc_data`  in  64 / `mem2proc_tag`  in  4  data return, tag 0 = none
- `outstanding_cnt`  out  4  number of valid tag-table entries
- `stray_tag_err`  out  1  sticky: a return arrived for an unowned tag

## Operation
- Effective requests: `d_ok = dcache_req && dcache_cmd != BUS_NONE`; `i_ok = icache_req`.
- Winner (combinational): icache if `i_ok && (!d_ok || starve_cnt == STARVE_LIMIT)`; else dcache if `d_ok`; else none.
- Bus drive: winner's address/data; command BUS_LOAD for icache, `dcache_cmd` for dcache; no winner → BUS_NONE, addr/data 0.
- Ack: `<winner>_ack = (mem2proc_response != 0)`; `<winner>_tag = mem2proc_response`; loser ack 0. Requester holds req/addr/data until ack.
- Tag table: NUM_TAGS+1 entries {valid, owner}. On an accepted LOAD, entry[response] ← {1, winner} at the clock edge. Accepted STORE: no entry (stores complete on acceptance).
- Return: when `mem2proc_tag != 0` and entry valid, assert owner's `*_data_valid` combinationally with `mem2proc_data`; clear entry at the edge. Invalid entry: no data_valid; `stray_tag_err` set at edge, held until reset.
- Same-tag return and new accept in one cycle: clear then set → entry ends valid with the new owner.
- `starve_cnt`: +1 (saturating at STARVE_LIMIT) each cycle `icache_req && !icache_ack`; 0 when icache acked or `icache_req` low.
- `outstanding_cnt` = popcount of valid entries (registered state).

## Timing
- Request→ack: same cycle as memory response (combinational path req→command→response→ack). No added latency.
- Data return: zero-cycle pass-through from `mem2proc_*` to `*_data_valid/*_data`.
- Reset (async, immediate): table cleared, starve_cnt 0, stray_tag_err 0, outstanding_cnt 0; combinational outputs then follow inputs (with no requests: command BUS_NONE, all acks/valids 0, tags/data 0). Reset mid-transaction drops all outstanding ownership; later returns flag stray_tag_err.
- Rejection (response 0): nothing recorded; requester retries next cycle; arbitration re-evaluated each cycle (a denied dcache may lose to a newly-starved icache).

## Structure
- Shared package (sys_defs): BUS_COMMAND (existing), `MEM_OWNER` enum {OWN_ICACHE, OWN_DCACHE}, `NUM_MEM_TAGS`, tag-entry struct {valid, owner}.
- Sub-module `mem_tag_table`: entry array, set/clear ports, lookup by return tag, popcount output. Arbitration and starvation counter stay in the top.

## Test plan
- dcache LOAD 0x1000 alone, response 3 → dcache_ack=1, tag 3, outstanding 1; later tag 3 with data 0xDEAD → dcache_data_valid=1, data 0xDEAD, outstanding 0.
- Both request continuously, response always nonzero, STARVE_LIMIT=4 → dcache wins cycles 0–3, icache wins cycle 4, counter returns to 0.
- dcache STORE 0x2000 data 0x55, response 5 → ack, proc2mem_command=BUS_STORE, outstanding stays 0.
- Response 0 for 3 cycles then 7 → no acks until cycle 4; bus held stable; tag 7 recorded for correct owner.
- Return tag 9 and accept tag 9 (icache) same cycle → old owner gets data_valid; entry 9 valid, owner icache after edge.
- Return tag 2 with no entry → no data_valid; stray_tag_err=1 until async reset asserted mid-cycle clears all state.
